// File: rtl/fifo_row_loader_pkg.sv
// Shared types and helpers for the row loader that feeds a systolic array's per-row delay FIFO.
package fifo_row_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKEW,
        SHIFT,
        FLUSH
    } loader_state_t;

    // Counter wide enough to hold the value depth itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_row_loader.sv
// Accepts a full row in parallel and then emits it one word per array step: first SKEW zero
// words, then the row with word 0 first. Defining FIFO_ROW_LOADER_FLUSH_EN appends DEPTH zero words.
module fifo_row_loader #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64,
    parameter int SKEW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEPTH*BITS-1:0] in_row,
    input  logic                  step,
    output logic                  out_en,
    output logic [BITS-1:0]       out_d,
    output logic                  busy,
    output logic                  done
);
    import fifo_row_loader_pkg::*;

    localparam int CW = cnt_width(DEPTH);
    // The parameter SKEW hides the package's state name, so the state gets a local alias.
    localparam loader_state_t ST_SKEW   = fifo_row_loader_pkg::SKEW;
    localparam logic [CW-1:0] SKEW_LAST = CW'((SKEW > 0) ? SKEW - 1 : 0);
    localparam logic [CW-1:0] WORD_LAST = CW'(DEPTH - 1);

    loader_state_t         state_q;
    logic [CW-1:0]         cnt_q;
    logic [DEPTH*BITS-1:0] row_q;
    logic                  done_q;

    // NOTE: all state updates use non-blocking assignments, so each register reads the values
    // held before the clock edge, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: clearing the row register is deliberate; a stale row must never reach out_d.
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        row_q   <= in_row;
                        cnt_q   <= '0;
                        state_q <= (SKEW > 0) ? ST_SKEW : SHIFT;
                    end
                end
                ST_SKEW: begin
                    if (step) begin
                        if (cnt_q == SKEW_LAST) begin
                            cnt_q   <= '0;
                            state_q <= SHIFT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (step) begin
                        if (cnt_q == WORD_LAST) begin
                            cnt_q   <= '0;
`ifdef FIFO_ROW_LOADER_FLUSH_EN
                            state_q <= FLUSH;
`else
                            state_q <= IDLE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
`ifdef FIFO_ROW_LOADER_FLUSH_EN
                FLUSH: begin
                    // Zero words push the data out of the downstream delay FIFO.
                    if (step) begin
                        if (cnt_q == WORD_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // NOTE: out_d receives a default before the mux loop, so no latch is inferred when no
    // branch matches.
    always_comb begin
        out_d = '0;
        if (state_q == SHIFT) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (cnt_q == CW'(k)) begin
                    out_d = row_q[k*BITS +: BITS];
                end
            end
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign out_en   = step & busy;
    assign done     = done_q;

endmodule

// File: tb/tb_fifo_row_loader.sv
// Two loaders (SKEW=2 and SKEW=0, DEPTH=4, BITS=8) driven in parallel, with directed scenarios
// and random traffic. Both are checked each cycle against a list-of-pending-emissions model.
module tb_fifo_row_loader;

`ifdef FIFO_ROW_LOADER_FLUSH_EN
    localparam int FLUSH_WORDS = 4;
`else
    localparam int FLUSH_WORDS = 0;
`endif
    localparam int DEPTH = 4;
    localparam logic [31:0] ROW1 = 32'h4433_2211;
    localparam logic [31:0] ROWA = 32'hAAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_row;
    logic        step;

    logic       in_ready_a, out_en_a, busy_a, done_a;
    logic [7:0] out_d_a;
    logic       in_ready_b, out_en_b, busy_b, done_b;
    logic [7:0] out_d_b;

    always #5 clk = ~clk;

    fifo_row_loader #(.DEPTH(4), .BITS(8), .SKEW(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_row(in_row),
        .step(step), .out_en(out_en_a), .out_d(out_d_a), .busy(busy_a), .done(done_a)
    );

    fifo_row_loader #(.DEPTH(4), .BITS(8), .SKEW(0)) u_dut_skew0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_row(in_row),
        .step(step), .out_en(out_en_b), .out_d(out_d_b), .busy(busy_b), .done(done_b)
    );

    // Downstream delay FIFO fed by the SKEW=2 loader; dfifo[0] holds the newest word.
    logic [7:0] dfifo [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) dfifo[j] <= 8'h00;
        end else if (out_en_a) begin
            dfifo[0] <= out_d_a;
            for (int j = 1; j < DEPTH; j++) dfifo[j] <= dfifo[j-1];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted row becomes a list of the words the loader still owes.
    logic [7:0] em [2][16];
    int         em_len [2];
    int         em_pos [2];
    logic       done_p [2];
    logic       acc    [2];
    logic [7:0] log_a [$];
    logic [7:0] log_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input int i, input logic r, input logic v,
                               input logic [31:0] row, input logic s);
        logic       g_rdy, g_en, g_busy, g_done, b, dn;
        logic [7:0] g_d, exp_d;
        string      nm;
        int         skew;
        if (i == 0) begin
            g_rdy = in_ready_a; g_en = out_en_a; g_busy = busy_a; g_done = done_a; g_d = out_d_a;
            nm = "skew2"; skew = 2;
        end else begin
            g_rdy = in_ready_b; g_en = out_en_b; g_busy = busy_b; g_done = done_b; g_d = out_d_b;
            nm = "skew0"; skew = 0;
        end
        b     = (em_pos[i] < em_len[i]);
        exp_d = b ? em[i][em_pos[i]] : 8'h00;
        check({nm, "_busy"},     {31'b0, g_busy}, {31'b0, b});
        check({nm, "_in_ready"}, {31'b0, g_rdy},  {31'b0, !b});
        check({nm, "_out_en"},   {31'b0, g_en},   {31'b0, s && b});
        check({nm, "_out_d"},    {24'b0, g_d},    {24'b0, exp_d});
        check({nm, "_done"},     {31'b0, g_done}, {31'b0, done_p[i]});
        if (g_en) begin
            if (i == 0) log_a.push_back(g_d);
            else        log_b.push_back(g_d);
        end
        acc[i] = 1'b0;
        if (r) begin
            em_len[i] = 0;
            em_pos[i] = 0;
            done_p[i] = 1'b0;
        end else begin
            dn = 1'b0;
            if (b && s) begin
                em_pos[i]++;
                if (em_pos[i] == em_len[i]) dn = 1'b1;
            end
            if (!b && v) begin
                acc[i]    = 1'b1;
                em_len[i] = 0;
                em_pos[i] = 0;
                for (int k = 0; k < skew; k++)        em[i][em_len[i]++] = 8'h00;
                for (int k = 0; k < DEPTH; k++)       em[i][em_len[i]++] = row[8*k +: 8];
                for (int k = 0; k < FLUSH_WORDS; k++) em[i][em_len[i]++] = 8'h00;
            end
            done_p[i] = dn;
        end
    endtask

    task automatic run_cycle(input logic r, input logic v, input logic [31:0] row, input logic s);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_row = row; step = s;
        @(negedge clk);
        model_cycle(0, r, v, row, s);
        model_cycle(1, r, v, row, s);
    endtask

    // Checks the SKEW=2 loader's emitted sequence against the literal pattern for one row.
    task automatic check_log_a(input string tag, input logic [31:0] row);
        logic [7:0] exp, got;
        check({tag, "_count"}, log_a.size(), 6 + FLUSH_WORDS);
        for (int j = 0; j < 6 + FLUSH_WORDS; j++) begin
            exp = (j >= 2 && j < 6) ? row[8*(j-2) +: 8] : 8'h00;
            got = (j < log_a.size()) ? log_a[j] : 8'hxx;
            check($sformatf("%s_word%0d", tag, j), {24'b0, got}, {24'b0, exp});
        end
    endtask

    initial begin
        logic        hold, r, v, s;
        logic [31:0] row;
        int          k;
        rst = 1'b1; in_valid = 1'b0; in_row = '0; step = 1'b0;
        for (int i = 0; i < 2; i++) begin
            em_len[i] = 0; em_pos[i] = 0; done_p[i] = 1'b0; acc[i] = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Reset state, including in_valid on the reset edge.
        run_cycle(1, 1, ROW1, 1);
        run_cycle(0, 0, 0, 1);
        check("reset_ready", {31'b0, in_ready_a}, 32'd1);

        // Scenario 1: straight emission with step held high.
        log_a.delete();
        run_cycle(0, 1, ROW1, 1);
        repeat (7 + FLUSH_WORDS) run_cycle(0, 0, 0, 1);
        check_log_a("s1", ROW1);
        check("s1_done",  {31'b0, done_a},     32'd1);
        check("s1_ready", {31'b0, in_ready_a}, 32'd1);
        for (int j = 0; j < DEPTH; j++)
            check($sformatf("s1_dfifo%0d", j), {24'b0, dfifo[j]},
                  (FLUSH_WORDS > 0) ? 32'h0 : {24'b0, ROW1[8*(DEPTH-1-j) +: 8]});

        // Scenario 2: step toggling.
        run_cycle(1, 0, 0, 0);
        log_a.delete();
        run_cycle(0, 1, ROW1, 1);
        for (int j = 0; j < 2 * (6 + FLUSH_WORDS) + 2; j++) run_cycle(0, 0, 0, (j % 2) == 1);
        check_log_a("s2", ROW1);

        // Scenario 3: second row held while busy; accepted in the done cycle.
        run_cycle(1, 0, 0, 0);
        log_a.delete();
        run_cycle(0, 1, ROW1, 1);
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            run_cycle(0, 1, ROWA, 1);
            check("s3_ready", {31'b0, in_ready_a}, {31'b0, j == 7 + FLUSH_WORDS});
            k = j;
            if (acc[0]) break;
        end
        check("s3_accept_cycle", k, 7 + FLUSH_WORDS);
        repeat (8 + FLUSH_WORDS) run_cycle(0, 0, 0, 1);
        check("s3_count", log_a.size(), 2 * (6 + FLUSH_WORDS));

        // Scenario 4: reset after two data words.
        run_cycle(1, 0, 0, 0);
        log_a.delete();
        run_cycle(0, 1, ROW1, 1);
        repeat (4) run_cycle(0, 0, 0, 1);
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 0, 0, 1);
        check("s4_busy",     {31'b0, busy_a},     32'd0);
        check("s4_in_ready", {31'b0, in_ready_a}, 32'd1);
        check("s4_out_en",   {31'b0, out_en_a},   32'd0);
        repeat (6) run_cycle(0, 0, 0, 1);
        check("s4_count", log_a.size(), 4);

        // Scenario 5: SKEW=0 emits word 0 the cycle after acceptance.
        run_cycle(1, 0, 0, 0);
        log_b.delete();
        run_cycle(0, 1, ROW1, 1);
        run_cycle(0, 0, 0, 1);
        check("s5_first_en", {31'b0, out_en_b}, 32'd1);
        check("s5_first_d",  {24'b0, out_d_b},  32'h11);
        repeat (6 + FLUSH_WORDS) run_cycle(0, 0, 0, 1);
        check("s5_count", log_b.size(), 4 + FLUSH_WORDS);

        // Random traffic; the sender holds a row until the SKEW=2 loader accepts it.
        hold = 1'b0; v = 1'b0; row = '0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if (!hold) begin
                v   = ($urandom_range(0, 3) != 0);
                row = $urandom;
            end
            s = ($urandom_range(0, 3) != 0);
            run_cycle(r, v, row, s);
            hold = v && !acc[0] && !r;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_row_loader.md
Name: fifo_row_loader

Overview:
- Write-side feeder for the systolic array's per-row delay FIFOs.
- Accepts one full row of DEPTH words in parallel over a valid/ready handshake, then serializes it into the downstream delay FIFO one word per array step.
- Drives the FIFO's d and en inputs. Prepends SKEW zero words first, so rows enter the array diagonally staggered.
- One instance per array row; the row index sets SKEW.

Parameters:
- DEPTH, 8, words per row; equals the downstream FIFO depth.
- BITS, 64, width of one word.
- SKEW, 0, zero words emitted before row data. Legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  row presented on in_row.
- in_ready  output  1  loader can accept a row.
- in_row  input  DEPTH*BITS  row; word k = in_row[k*BITS +: BITS]; word 0 leaves first.
- step  input  1  array advance enable; loader emits at most one word per cycle with step=1.
- out_en  output  1  drives the FIFO en input.
- out_d  output  BITS  drives the FIFO d input.
- busy  output  1  high while a row is being emitted.
- done  output  1  one-cycle pulse after the final emission.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - state=IDLE; row register, counter and done cleared.
  - Outputs while in IDLE after reset: in_ready=1, out_en=0, out_d=0, busy=0, done=0.
  - Reset mid-row abandons the row and emits nothing further.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_row and clear the counter. Next state is SKEW if SKEW>0, else SHIFT.
  - SKEW: in_ready=0. Each cycle with step=1: out_en=1, out_d=0, counter+1. After the SKEW-th emission, clear the counter and go to SHIFT.
  - SHIFT: each cycle with step=1: out_en=1, out_d=word[counter], counter+1. After word DEPTH-1, go to FLUSH if compiled in; otherwise go to IDLE and set done.
  - FLUSH: see Optional Feature.
- Output decode:
  - out_en = step & (state != IDLE), combinational.
  - out_d is a combinational mux of the row register. It is 0 outside SHIFT.
  - busy = (state != IDLE).
  - done is registered: high exactly one cycle, coincident with the first IDLE cycle after completion.
- Latency and throughput:
  - First out_en can occur the cycle after acceptance.
  - With step held high, the next row is accepted SKEW+DEPTH(+flush) cycles after the previous acceptance, plus 1 idle cycle.
- step=0: counter and state are frozen, out_en=0, and no word is lost or duplicated.
- in_valid while busy: in_ready=0, and in_row is ignored and not latched. The sender must hold in_valid and in_row until accepted.
- Counter: width $clog2(DEPTH+1). It never exceeds DEPTH, and no wrap-around is permitted.
- SKEW=0: IDLE goes directly to SHIFT, and the SKEW state is unreachable.
- in_valid=1 on the same edge as rst=1: reset wins and the row is not captured.

Optional Feature:
- Macro: FIFO_ROW_LOADER_FLUSH_EN.
- When defined:
  - After the last SHIFT emission, enter FLUSH.
  - FLUSH emits DEPTH words of 0 (out_en=step, counter-gated), which drains the delay FIFO to all zeros.
  - Then go to IDLE and pulse done.
- When undefined:
  - The FLUSH state and its logic are absent.
  - done follows the last data word.

Decomposition:
- Package fifo_row_loader_pkg:
  - typedef enum logic [1:0] {IDLE, SKEW, SHIFT, FLUSH} loader_state_t.
  - Function cnt_width(depth) returning $clog2(depth+1).
- No sub-module: a single FSM plus counter plus row mux.
- The downstream delay FIFO is instantiated by the parent, not inside this block.

Test Plan:
- Use DEPTH=4, BITS=8, SKEW=2, step=1, and no FLUSH for these scenarios unless stated.
1. Accept row {0x44,0x33,0x22,0x11} (word0=0x11) -> out_en high 6 consecutive cycles; out_d = 00,00,11,22,33,44; done pulses the following cycle with in_ready=1.
2. Same row with step toggling 1,0,1,0… -> out_en only on step=1 cycles; same 6-word sequence; no repeats or drops.
3. in_valid held during busy with a second row 0xAA.. -> in_ready=0 until done. The second row is accepted in the done cycle, with no corruption of the first row's outputs.
4. rst=1 after two data words -> next cycle: busy=0, in_ready=1, out_en=0; the remaining words are never emitted.
5. SKEW=0 -> first out_d=0x11 the cycle after acceptance; exactly 4 emissions.
6. FIFO_ROW_LOADER_FLUSH_EN defined, SKEW=2 -> 6 emissions as in scenario 1, then 4 zero words with out_en=1, then done. A connected delay FIFO reads all zeros afterwards.
